// File: rtl/matrix_pkg.sv
// Shared constants and encodings for the LED-matrix blitter.
// Also holds the sequencer states and the row-transform opcodes.
package matrix_pkg;

   localparam int ROWS      = 8;
   localparam int GREEN_LSB = 0;
   localparam int RED_LSB   = 8;

   localparam logic [2:0] LAST_ROW       = 3'(ROWS - 1);
   localparam logic [2:0] SHIFT_LAST_ROW = 3'(ROWS - 2);

   localparam logic [2:0] CMD_NOP         = 3'd0;
   localparam logic [2:0] CMD_CLEAR       = 3'd1;
   localparam logic [2:0] CMD_SET_PIXEL   = 3'd2;
   localparam logic [2:0] CMD_FILL_ROW    = 3'd3;
   localparam logic [2:0] CMD_SCROLL_LEFT = 3'd4;
   localparam logic [2:0] CMD_SHIFT_UP    = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR
   } state_t;

   typedef enum logic [2:0] {
      ALU_PASS,
      ALU_PIXEL,
      ALU_ROWFILL,
      ALU_SCROLL,
      ALU_BLANK
   } alu_op_t;

endpackage

// File: rtl/matrix_blitter_if.sv
// Command handshake plus frame-RAM port of the blitter.
// The slave modport is the blitter's view; master is the CPU/driver side.
interface matrix_blitter_if;

   logic [2:0]  CMD;
   logic [2:0]  CMD_X;
   logic [2:0]  CMD_Y;
   logic [1:0]  CMD_COLOR;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic        DONE;
   logic [2:0]  M_ADDR;
   logic [15:0] M_DATA;
   logic        M_WREN;
   logic [15:0] M_Q;

   modport slave (
      input  CMD, CMD_X, CMD_Y, CMD_COLOR, CMD_VALID, M_Q,
      output CMD_READY, DONE, M_ADDR, M_DATA, M_WREN
   );

   modport master (
      output CMD, CMD_X, CMD_Y, CMD_COLOR, CMD_VALID, M_Q,
      input  CMD_READY, DONE, M_ADDR, M_DATA, M_WREN
   );

endinterface

// File: rtl/matrix_row_alu.sv
// Combinational row-word transform: pixel merge, row fill, scroll, pass and blank.
// Row word is {red[7:0], green[7:0]}; bit X of each byte is column X.
module matrix_row_alu
   import matrix_pkg::*;
(
   input  alu_op_t     op,
   input  logic [15:0] word,
   input  logic [2:0]  x,
   input  logic [1:0]  color,
   input  logic        fill,
   output logic [15:0] wr_word
);

   logic [7:0] col_mask;
   logic [7:0] green_in;
   logic [7:0] red_in;

   assign col_mask = 8'd1 << x;
   assign green_in = word[GREEN_LSB +: 8];
   assign red_in   = word[RED_LSB +: 8];

   always_comb begin
      wr_word = word;
      case (op)
         ALU_PIXEL: begin
            wr_word[GREEN_LSB +: 8] = (green_in & ~col_mask) | (color[0] ? col_mask : 8'h00);
            wr_word[RED_LSB +: 8]   = (red_in & ~col_mask)   | (color[1] ? col_mask : 8'h00);
         end
         ALU_ROWFILL: begin
            wr_word[GREEN_LSB +: 8] = {8{color[0]}};
            wr_word[RED_LSB +: 8]   = {8{color[1]}};
         end
         // Column 7 falls off; fill enters at column 0 in both colours.
         ALU_SCROLL: begin
            wr_word[GREEN_LSB +: 8] = {green_in[6:0], fill};
            wr_word[RED_LSB +: 8]   = {red_in[6:0], fill};
         end
         ALU_BLANK: wr_word = {16{fill}};
         default:   wr_word = word;
      endcase
   end

endmodule

// File: rtl/matrix_blitter.sv
// Command sequencer that turns drawing commands into row read/modify/write
// traffic on the LED-matrix frame RAM port; all outputs are registered.
module matrix_blitter
   import matrix_pkg::*;
#(
   parameter logic SHIFT_FILL = 1'b0
) (
   input  logic             CLK,
   input  logic             RST_N,
   matrix_blitter_if.slave  bus
);

   state_t      state;
   logic [2:0]  row;
   logic [2:0]  op_q;
   logic [2:0]  x_q;
   logic [2:0]  y_q;
   logic [1:0]  color_q;

   alu_op_t     alu_op;
   logic [1:0]  alu_color;
   logic [15:0] alu_word;
   logic        wr_last;

   // Command fields are plain data: captured on acceptance, never reset.
   always_ff @(posedge CLK) begin
      if (state == ST_IDLE && bus.CMD_VALID) begin
         op_q    <= bus.CMD;
         x_q     <= bus.CMD_X;
         y_q     <= bus.CMD_Y;
         color_q <= bus.CMD_COLOR;
      end
   end

   // FILL_ROW writes in the first cycle, so its colour comes straight off the bus.
   always_comb begin
      alu_op    = ALU_PASS;
      alu_color = color_q;
      if (state == ST_IDLE) begin
         alu_op    = ALU_ROWFILL;
         alu_color = bus.CMD_COLOR;
      end else begin
         case (op_q)
            CMD_SET_PIXEL:   alu_op = ALU_PIXEL;
            CMD_SCROLL_LEFT: alu_op = ALU_SCROLL;
            CMD_SHIFT_UP:    alu_op = (state == ST_WR) ? ALU_BLANK : ALU_PASS;
            default:         alu_op = ALU_PASS;
         endcase
      end
   end

   matrix_row_alu u_alu (
      .op      (alu_op),
      .word    (bus.M_Q),
      .x       (x_q),
      .color   (alu_color),
      .fill    (SHIFT_FILL),
      .wr_word (alu_word)
   );

   always_comb begin
      wr_last = 1'b1;
      case (op_q)
         CMD_CLEAR,
         CMD_SCROLL_LEFT,
         CMD_SHIFT_UP:    wr_last = (row == LAST_ROW);
         default:         wr_last = 1'b1;
      endcase
   end

   // Completion folds into IDLE: DONE pulses in the first idle cycle, with CMD_READY.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= ST_IDLE;
         row           <= 3'd0;
         bus.M_ADDR    <= 3'd0;
         bus.M_DATA    <= 16'h0000;
         bus.M_WREN    <= 1'b0;
         bus.DONE      <= 1'b0;
         bus.CMD_READY <= 1'b1;
      end else begin
         bus.DONE   <= 1'b0;
         bus.M_WREN <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.CMD_VALID) begin
                  row <= 3'd0;
                  case (bus.CMD)
                     CMD_CLEAR: begin
                        state         <= ST_WR;
                        bus.M_ADDR    <= 3'd0;
                        bus.M_DATA    <= 16'h0000;
                        bus.M_WREN    <= 1'b1;
                        bus.CMD_READY <= 1'b0;
                     end
                     CMD_SET_PIXEL: begin
                        state         <= ST_RD;
                        bus.M_ADDR    <= bus.CMD_Y;
                        bus.CMD_READY <= 1'b0;
                     end
                     CMD_FILL_ROW: begin
                        state         <= ST_WR;
                        bus.M_ADDR    <= bus.CMD_Y;
                        bus.M_DATA    <= alu_word;
                        bus.M_WREN    <= 1'b1;
                        bus.CMD_READY <= 1'b0;
                     end
                     CMD_SCROLL_LEFT: begin
                        state         <= ST_RD;
                        bus.M_ADDR    <= 3'd0;
                        bus.CMD_READY <= 1'b0;
                     end
                     CMD_SHIFT_UP: begin
                        state         <= ST_RD;
                        bus.M_ADDR    <= 3'd1;
                        bus.CMD_READY <= 1'b0;
                     end
                     default: bus.DONE <= 1'b1;
                  endcase
               end
            end
            ST_RD: state <= ST_CAP;
            ST_CAP: begin
               state      <= ST_WR;
               bus.M_ADDR <= (op_q == CMD_SET_PIXEL) ? y_q : row;
               bus.M_DATA <= alu_word;
               bus.M_WREN <= 1'b1;
            end
            ST_WR: begin
               if (wr_last) begin
                  state         <= ST_IDLE;
                  bus.DONE      <= 1'b1;
                  bus.CMD_READY <= 1'b1;
               end else begin
                  row <= row + 3'd1;
                  case (op_q)
                     CMD_CLEAR: begin
                        bus.M_ADDR <= row + 3'd1;
                        bus.M_DATA <= 16'h0000;
                        bus.M_WREN <= 1'b1;
                     end
                     // After the row-6 copy, row 7 is blanked with a single write.
                     CMD_SHIFT_UP: begin
                        if (row == SHIFT_LAST_ROW) begin
                           bus.M_ADDR <= LAST_ROW;
                           bus.M_DATA <= alu_word;
                           bus.M_WREN <= 1'b1;
                        end else begin
                           state      <= ST_RD;
                           bus.M_ADDR <= row + 3'd2;
                        end
                     end
                     default: begin
                        state      <= ST_RD;
                        bus.M_ADDR <= row + 3'd1;
                     end
                  endcase
               end
            end
            default: begin
               state         <= ST_IDLE;
               bus.CMD_READY <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_blitter.sv
// Scoreboard bench for matrix_blitter: expected writes/DONE pulses are queued
// with their cycle offsets when a command is issued and checked by a monitor.
module tb_matrix_blitter;
   import matrix_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   matrix_blitter_if bus ();

   matrix_blitter #(.SHIFT_FILL(1'b0)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] ram [8];

   // Frame RAM model: read data appears the cycle after the address.
   always @(posedge clk) begin
      bus.M_Q <= ram[bus.M_ADDR];
      if (bus.M_WREN) ram[bus.M_ADDR] <= bus.M_DATA;
   end

   typedef struct {
      bit          is_done;
      int          rel;
      logic [2:0]  addr;
      logic [15:0] data;
   } ev_t;

   ev_t sb[$];
   ev_t cur;
   int  rel   = 0;
   int  n_vec = 0;
   int  n_bad = 0;

   localparam logic [15:0] SCR_IN  [8] = '{16'h8001, 16'h0000, 16'h2020, 16'hFFFF,
                                          16'h00FF, 16'h8080, 16'h1234, 16'hC3A5};
   localparam logic [15:0] SCR_OUT [8] = '{16'h0002, 16'h0000, 16'h4040, 16'hFEFE,
                                          16'h00FE, 16'h0000, 16'h2468, 16'h864A};

   task automatic push_wr(input int r, input logic [2:0] a, input logic [15:0] d);
      ev_t ev;
      ev.is_done = 1'b0; ev.rel = r; ev.addr = a; ev.data = d;
      sb.push_back(ev);
   endtask

   task automatic push_done(input int r);
      ev_t ev;
      ev.is_done = 1'b1; ev.rel = r; ev.addr = 3'd0; ev.data = 16'h0000;
      sb.push_back(ev);
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance.
   task automatic send(input logic [2:0] c, input logic [2:0] x, input logic [2:0] y,
                       input logic [1:0] col, input bit keep);
      int n;
      bus.CMD = c; bus.CMD_X = x; bus.CMD_Y = y; bus.CMD_COLOR = col;
      bus.CMD_VALID = 1'b1;
      n = 0;
      while (!bus.CMD_READY && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         n_vec++; n_bad++;
         $display("FAIL send_timeout cmd=%0d ready=%0b want ready=1", c, bus.CMD_READY);
      end
      @(posedge clk); #1;
      if (!keep) bus.CMD_VALID = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(sb.size() == 0 && bus.CMD_READY) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         n_vec++; n_bad++;
         $display("FAIL idle_timeout pending=%0d ready=%0b want pending=0 ready=1",
                  sb.size(), bus.CMD_READY);
      end
   endtask

   always @(negedge clk) begin
      rel = rel + 1;
      if (rst_n && (bus.M_WREN || bus.DONE)) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected got wren=%0b done=%0b addr=%0d data=%h want nothing",
                     bus.M_WREN, bus.DONE, bus.M_ADDR, bus.M_DATA);
         end else begin
            cur = sb.pop_front();
            if (cur.is_done != bus.DONE || cur.rel != rel ||
                (!cur.is_done && (cur.addr !== bus.M_ADDR || cur.data !== bus.M_DATA))) begin
               n_bad++;
               $display("FAIL sb_event got done=%0b cyc=%0d addr=%0d data=%h want done=%0b cyc=%0d addr=%0d data=%h",
                        bus.DONE, rel, bus.M_ADDR, bus.M_DATA,
                        cur.is_done, cur.rel, cur.addr, cur.data);
            end
         end
      end
      if (bus.CMD_VALID && bus.CMD_READY) rel = 0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.CMD = 3'd0; bus.CMD_X = 3'd0; bus.CMD_Y = 3'd0;
      bus.CMD_COLOR = 2'd0; bus.CMD_VALID = 1'b0;
      for (int i = 0; i < 8; i++) ram[i] = 16'h0000;

      #12;
      chk("rst_addr",  16'(bus.M_ADDR), 16'h0000);
      chk("rst_data",  bus.M_DATA, 16'h0000);
      chk("rst_wren",  16'(bus.M_WREN), 16'h0000);
      chk("rst_done",  16'(bus.DONE), 16'h0000);
      chk("rst_ready", 16'(bus.CMD_READY), 16'h0001);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // CLEAR over a fully lit frame
      for (int i = 0; i < 8; i++) ram[i] = 16'hFFFF;
      for (int r = 0; r < 8; r++) push_wr(r + 1, 3'(r), 16'h0000);
      push_done(9);
      send(CMD_CLEAR, 3'd0, 3'd0, 2'd0, 1'b0);
      wait_idle();
      for (int r = 0; r < 8; r++) chk("clear_row", ram[r], 16'h0000);

      // SET_PIXEL then FILL_ROW with CMD_VALID held high across the busy window
      push_wr(3, 3'd2, 16'h2020);
      push_done(4);
      push_wr(1, 3'd7, 16'h00FF);
      push_done(2);
      send(CMD_SET_PIXEL, 3'd5, 3'd2, 2'b11, 1'b1);
      chk("ready_busy", 16'(bus.CMD_READY), 16'h0000);
      send(CMD_FILL_ROW, 3'd0, 3'd7, 2'b01, 1'b0);
      wait_idle();
      chk("pixel_row2", ram[2], 16'h2020);
      chk("fill_row7",  ram[7], 16'h00FF);

      // SCROLL_LEFT
      for (int i = 0; i < 8; i++) ram[i] = SCR_IN[i];
      for (int r = 0; r < 8; r++) push_wr(3 * r + 3, 3'(r), SCR_OUT[r]);
      push_done(25);
      send(CMD_SCROLL_LEFT, 3'd0, 3'd0, 2'd0, 1'b0);
      wait_idle();
      for (int r = 0; r < 8; r++) chk("scroll_row", ram[r], SCR_OUT[r]);

      // SHIFT_UP
      for (int i = 0; i < 8; i++) ram[i] = 16'h0101 << i;
      for (int r = 0; r < 7; r++) push_wr(3 * r + 3, 3'(r), 16'h0101 << (r + 1));
      push_wr(22, 3'd7, 16'h0000);
      push_done(23);
      send(CMD_SHIFT_UP, 3'd0, 3'd0, 2'd0, 1'b0);
      wait_idle();
      chk("shup_row0", ram[0], 16'h0202);
      chk("shup_row6", ram[6], 16'h8080);
      chk("shup_row7", ram[7], 16'h0000);

      // Reserved code 6: DONE only
      push_done(1);
      send(3'd6, 3'd3, 3'd3, 2'b11, 1'b0);
      wait_idle();
      chk("rsv_row0", ram[0], 16'h0202);
      chk("rsv_row3", ram[3], 16'h1010);
      chk("rsv_row7", ram[7], 16'h0000);

      // Reset in cycle 10 of SCROLL_LEFT: rows 0..2 already rewritten
      for (int i = 0; i < 8; i++) ram[i] = SCR_IN[i];
      for (int r = 0; r < 3; r++) push_wr(3 * r + 3, 3'(r), SCR_OUT[r]);
      send(CMD_SCROLL_LEFT, 3'd0, 3'd0, 2'd0, 1'b0);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_wren",  16'(bus.M_WREN), 16'h0000);
      chk("abort_done",  16'(bus.DONE), 16'h0000);
      chk("abort_addr",  16'(bus.M_ADDR), 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready", 16'(bus.CMD_READY), 16'h0001);
      repeat (3) @(posedge clk);
      #1;
      for (int r = 0; r < 3; r++) chk("abort_shifted", ram[r], SCR_OUT[r]);
      for (int r = 3; r < 8; r++) chk("abort_kept", ram[r], SCR_IN[r]);

      chk("sb_drained", 16'(sb.size()), 16'h0000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
